// File: rtl/serial_pkg.sv
// Shared definitions for the serial port controller: byte width and TX sequencer states.
package serial_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with registered occupancy count; push and pop in the same cycle
// are legal even when full.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this same cycle, so a push into a full FIFO can still land.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (do_push && !do_pop)
        count <= count + (ADDR_W+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/serial_port_controller.sv
// Buffers byte traffic between the processor serial port and a UART core, with an RX and a
// TX FIFO and a sequencer that hands TX bytes to the UART over its busy handshake.
module serial_port_controller
  import serial_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] cpu_wrdata_in,
  input  logic              cpu_wren_in,
  input  logic              cpu_rden_in,
  output logic [BYTE_W-1:0] cpu_rddata_out,
  output logic              cpu_valid_out,
  output logic              cpu_ready_out,
  input  logic [BYTE_W-1:0] uart_rx_data_in,
  input  logic              uart_rx_valid_in,
  output logic [BYTE_W-1:0] uart_tx_data_out,
  output logic              uart_tx_start_out,
  input  logic              uart_tx_busy_in,
  output logic [ADDR_W:0]   rx_count_out,
  output logic [ADDR_W:0]   tx_count_out,
  output logic              overflow_out,
  input  logic              overflow_clr_in
);

  logic              rx_full;
  logic              rx_empty;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic              rx_drop;
  logic              tx_drop;
  logic [BYTE_W-1:0] tx_head;
  tx_state_t         tx_state;

  byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (uart_rx_valid_in),
    .pop     (cpu_rden_in),
    .wr_data (uart_rx_data_in),
    .rd_data (cpu_rddata_out),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count_out)
  );

  byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .wr_data (cpu_wrdata_in),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count_out)
  );

  // A TX write into a full FIFO is dropped even if the sequencer pops in the same cycle.
  assign tx_push = cpu_wren_in && !tx_full;
  assign tx_drop = cpu_wren_in && tx_full;
  assign rx_drop = uart_rx_valid_in && rx_full && !cpu_rden_in;
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && !uart_tx_busy_in;

  assign cpu_valid_out = !rx_empty;
  assign cpu_ready_out = !tx_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state          <= TX_IDLE;
      uart_tx_start_out <= 1'b0;
      uart_tx_data_out  <= '0;
    end else begin
      uart_tx_start_out <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            uart_tx_data_out  <= tx_head;
            uart_tx_start_out <= 1'b1;
            tx_state          <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          if (uart_tx_busy_in) tx_state <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: begin
          if (!uart_tx_busy_in) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // A new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overflow_out <= 1'b0;
    else if (rx_drop || tx_drop)
      overflow_out <= 1'b1;
    else if (overflow_clr_in)
      overflow_out <= 1'b0;
  end

endmodule

// File: tb/tb_serial_port_controller.sv
// Self-checking bench for serial_port_controller: RX vector table, RX/TX scoreboards and a
// simple UART busy model.
module tb_serial_port_controller;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cpu_wrdata_in;
  logic       cpu_wren_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_rddata_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic [7:0] uart_rx_data_in;
  logic       uart_rx_valid_in;
  logic [7:0] uart_tx_data_out;
  logic       uart_tx_start_out;
  logic       uart_tx_busy_in;
  logic [4:0] rx_count_out;
  logic [4:0] tx_count_out;
  logic       overflow_out;
  logic       overflow_clr_in;

  serial_port_controller #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_wrdata_in     (cpu_wrdata_in),
    .cpu_wren_in       (cpu_wren_in),
    .cpu_rden_in       (cpu_rden_in),
    .cpu_rddata_out    (cpu_rddata_out),
    .cpu_valid_out     (cpu_valid_out),
    .cpu_ready_out     (cpu_ready_out),
    .uart_rx_data_in   (uart_rx_data_in),
    .uart_rx_valid_in  (uart_rx_valid_in),
    .uart_tx_data_out  (uart_tx_data_out),
    .uart_tx_start_out (uart_tx_start_out),
    .uart_tx_busy_in   (uart_tx_busy_in),
    .rx_count_out      (rx_count_out),
    .tx_count_out      (tx_count_out),
    .overflow_out      (overflow_out),
    .overflow_clr_in   (overflow_clr_in)
  );

  always #5 clock = ~clock;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] rx_expected[$];
  logic [7:0] tx_expected[$];
  logic       ovf_model = 1'b0;
  int         start_count = 0;
  logic       hold_busy = 1'b0;
  int         busy_cnt;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step_clock();
    @(posedge clock);
    #1;
  endtask

  // UART model: busy rises the edge after start and stays high for 10 cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      uart_tx_busy_in <= 1'b0;
      busy_cnt        <= 0;
    end else if (hold_busy) begin
      uart_tx_busy_in <= 1'b1;
    end else if (uart_tx_start_out) begin
      busy_cnt        <= 10;
      uart_tx_busy_in <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt        <= 0;
      uart_tx_busy_in <= 1'b0;
    end
  end

  // TX monitor: pops the scoreboard on each start and checks pulse width, gap and data hold.
  logic       prev_start = 1'b0;
  logic       prev_busy = 1'b0;
  logic       has_started = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_start  = 1'b0;
      prev_busy   = 1'b0;
      has_started = 1'b0;
    end else begin
      if (uart_tx_start_out) begin
        start_count++;
        check_output("tx_start_single_cycle", {31'b0, prev_start}, 32'd0);
        check_output("tx_gap_after_busy", {31'b0, prev_busy}, 32'd0);
        if (tx_expected.size() > 0) begin
          check_output("tx_data", {24'b0, uart_tx_data_out}, {24'b0, tx_expected.pop_front()});
        end else begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL tx_unexpected_start: got data %0h, expected no start", uart_tx_data_out);
        end
        has_started = 1'b1;
        last_data   = uart_tx_data_out;
      end else if (has_started && uart_tx_busy_in) begin
        check_output("tx_data_hold", {24'b0, uart_tx_data_out}, {24'b0, last_data});
      end
      prev_start = uart_tx_start_out;
      prev_busy  = uart_tx_busy_in;
    end
  end

  task automatic do_reset();
    reset            = 1'b1;
    cpu_wren_in      = 1'b0;
    cpu_rden_in      = 1'b0;
    uart_rx_valid_in = 1'b0;
    overflow_clr_in  = 1'b0;
    step_clock();
    rx_expected.delete();
    tx_expected.delete();
    ovf_model   = 1'b0;
    start_count = 0;
    reset       = 1'b0;
  endtask

  // One cycle of RX-side stimulus; the scoreboard tracks accepted bytes and the overflow flag.
  task automatic apply_stimulus(input logic rx_valid, input logic [7:0] rx_data,
                                input logic rden, input logic clr);
    logic pop_eff;
    logic push_ok;
    pop_eff = rden && (rx_expected.size() > 0);
    push_ok = rx_valid && ((rx_expected.size() < DEPTH) || pop_eff);
    uart_rx_valid_in = rx_valid;
    uart_rx_data_in  = rx_data;
    cpu_rden_in      = rden;
    overflow_clr_in  = clr;
    if (pop_eff)
      check_output("rx_pop_data", {24'b0, cpu_rddata_out}, {24'b0, rx_expected.pop_front()});
    if (push_ok) rx_expected.push_back(rx_data);
    if (rx_valid && !push_ok) ovf_model = 1'b1;
    else if (clr) ovf_model = 1'b0;
    step_clock();
    uart_rx_valid_in = 1'b0;
    cpu_rden_in      = 1'b0;
    overflow_clr_in  = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] data, input logic accept);
    cpu_wren_in   = 1'b1;
    cpu_wrdata_in = data;
    if (accept) tx_expected.push_back(data);
    else ovf_model = 1'b1;
    step_clock();
    cpu_wren_in = 1'b0;
  endtask

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rden;
    logic       exp_valid;
    logic [7:0] exp_rddata;
    logic [4:0] exp_count;
  } rx_vec_t;

  rx_vec_t vecs[8];

  initial begin
    bit done;
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 5'd2};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 5'd1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[4] = '{1'b1, 8'h77, 1'b1, 1'b1, 8'h77, 5'd1};
    vecs[5] = '{1'b1, 8'h88, 1'b1, 1'b1, 8'h88, 5'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0};

    reset            = 1'b1;
    cpu_wrdata_in    = 8'h00;
    cpu_wren_in      = 1'b0;
    cpu_rden_in      = 1'b0;
    uart_rx_data_in  = 8'h00;
    uart_rx_valid_in = 1'b0;
    overflow_clr_in  = 1'b0;
    #12;
    check_output("reset_valid", {31'b0, cpu_valid_out}, 32'd0);
    check_output("reset_ready", {31'b0, cpu_ready_out}, 32'd1);
    check_output("reset_rddata", {24'b0, cpu_rddata_out}, 32'h00);
    check_output("reset_start", {31'b0, uart_tx_start_out}, 32'd0);
    check_output("reset_txdata", {24'b0, uart_tx_data_out}, 32'h00);
    check_output("reset_ovf", {31'b0, overflow_out}, 32'd0);
    check_output("reset_rx_count", {27'b0, rx_count_out}, 32'd0);
    check_output("reset_tx_count", {27'b0, tx_count_out}, 32'd0);
    reset = 1'b0;

    // RX basics from the vector table.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].rx_valid, vecs[i].rx_data, vecs[i].rden, 1'b0);
      check_output($sformatf("vec%0d_valid", i), {31'b0, cpu_valid_out}, {31'b0, vecs[i].exp_valid});
      check_output($sformatf("vec%0d_rddata", i), {24'b0, cpu_rddata_out}, {24'b0, vecs[i].exp_rddata});
      check_output($sformatf("vec%0d_count", i), {27'b0, rx_count_out}, {27'b0, vecs[i].exp_count});
      check_output($sformatf("vec%0d_ovf", i), {31'b0, overflow_out}, 32'd0);
    end

    // RX overflow, then clear racing a new drop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    check_output("rx_full_count", {27'b0, rx_count_out}, 32'd16);
    check_output("rx_full_no_ovf", {31'b0, overflow_out}, 32'd0);
    apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    check_output("rx_drop_count", {27'b0, rx_count_out}, 32'd16);
    check_output("rx_drop_ovf", {31'b0, overflow_out}, 32'd1);
    apply_stimulus(1'b1, 8'hEF, 1'b0, 1'b1);
    check_output("clr_vs_drop_ovf", {31'b0, overflow_out}, 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("clr_ovf", {31'b0, overflow_out}, {31'b0, ovf_model});
    check_output("clr_ovf_zero", {31'b0, overflow_out}, 32'd0);

    // RX full with a pop on the 17th strobe: both happen, pointers wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    check_output("rx_pushpop_count", {27'b0, rx_count_out}, 32'd16);
    check_output("rx_pushpop_ovf", {31'b0, overflow_out}, 32'd0);
    check_output("rx_pushpop_head", {24'b0, cpu_rddata_out}, 32'h01);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("rx_drained_valid", {31'b0, cpu_valid_out}, 32'd0);
    check_output("rx_drained_sb", rx_expected.size(), 32'd0);

    // TX: two bytes through the UART handshake.
    do_reset();
    write_tx(8'h41, 1'b1);
    cpu_wren_in   = 1'b1;
    cpu_wrdata_in = 8'h42;
    tx_expected.push_back(8'h42);
    step_clock();
    cpu_wren_in = 1'b0;
    check_output("tx_latency_start", {31'b0, uart_tx_start_out}, 32'd1);
    check_output("tx_latency_data", {24'b0, uart_tx_data_out}, 32'h41);
    check_output("tx_count_after_start", {27'b0, tx_count_out}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step_clock();
      done = (start_count == 2) && !uart_tx_busy_in && (tx_expected.size() == 0);
    end
    check_output("tx_drain_done", {31'b0, done}, 32'd1);
    check_output("tx_start_count", start_count, 32'd2);
    check_output("tx_count_empty", {27'b0, tx_count_out}, 32'd0);

    // TX full while the UART stays busy.
    do_reset();
    hold_busy = 1'b1;
    step_clock();
    for (int i = 0; i < DEPTH - 1; i++) write_tx(8'h60 + 8'(i), 1'b1);
    check_output("tx_ready_at_15", {31'b0, cpu_ready_out}, 32'd1);
    write_tx(8'h6F, 1'b1);
    check_output("tx_ready_full", {31'b0, cpu_ready_out}, 32'd0);
    check_output("tx_full_count", {27'b0, tx_count_out}, 32'd16);
    check_output("tx_full_no_ovf", {31'b0, overflow_out}, 32'd0);
    write_tx(8'h70, 1'b0);
    check_output("tx_drop_ovf", {31'b0, overflow_out}, 32'd1);
    check_output("tx_drop_count", {27'b0, tx_count_out}, 32'd16);
    check_output("tx_no_start_busy", start_count, 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("tx_clr_ovf", {31'b0, overflow_out}, 32'd0);
    hold_busy = 1'b0;

    // Reset asserted mid-transmission with bytes still queued.
    do_reset();
    write_tx(8'h11, 1'b1);
    write_tx(8'h22, 1'b1);
    write_tx(8'h33, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = (start_count >= 1);
      if (!done) step_clock();
    end
    check_output("mid_first_start", {31'b0, done}, 32'd1);
    step_clock();
    step_clock();
    check_output("mid_tx_count", {27'b0, tx_count_out}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_output("mid_reset_tx_count", {27'b0, tx_count_out}, 32'd0);
    check_output("mid_reset_start", {31'b0, uart_tx_start_out}, 32'd0);
    check_output("mid_reset_ready", {31'b0, cpu_ready_out}, 32'd1);
    check_output("mid_reset_txdata", {24'b0, uart_tx_data_out}, 32'h00);
    check_output("mid_reset_valid", {31'b0, cpu_valid_out}, 32'd0);
    do_reset();
    write_tx(8'h55, 1'b1);
    step_clock();
    check_output("post_reset_idle_start", {31'b0, uart_tx_start_out}, 32'd1);
    check_output("post_reset_idle_data", {24'b0, uart_tx_data_out}, 32'h55);
    for (int i = 0; i < 20; i++) step_clock();
    check_output("post_reset_sb_empty", tx_expected.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
